dot_matrix_scan_engine: RTL and testbench
=========================================

# dot_matrix_scan_engine

Parametrised row-scan engine for common-row LED dot-matrix panels, replacing the fixed 8×8 hard-coded-glyph controller. It owns its scan-rate prescaler, a writable frame buffer (optionally double-buffered with a frame-synchronous swap handshake), and inserts a blanking slot between rows to suppress ghosting. It sits between the pattern-generation logic and the panel pins.

## Interface
- `ROWS`, 8: number of panel rows. Must be at least 2.
- `COLS`, 8: number of panel columns.
- `DIV`, 2500: `clk` cycles per scan tick. Must be at least 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  frame-buffer write strobe.
- `wr_row`  in  $clog2(ROWS)  row address for the write.
- `wr_data`  in  COLS  column pattern for `wr_row`; 1 = LED on.
- `swap_req`  in  1  request to swap to the back buffer (level).
- `swap_ack`  out  1  one-cycle pulse when a swap is taken.
- `frame_start`  out  1  one-cycle pulse when row 0 begins its SHOW slot.
- `dot_row`  out  ROWS  row drive, active-low one-hot. Row r drives bit ROWS-1-r.
- `dot_column`  out  COLS  column drive, active-high.

## Operation
- **Prescaler**
  - Counts 0..DIV-1.
  - `tick` is asserted when count == DIV-1; the counter returns to 0 on that edge.
- **Scan FSM**
  - States: BLANK and SHOW. Row index `r` runs 0..ROWS-1.
  - BLANK→SHOW on a tick: `dot_row` = all ones except bit ROWS-1-r = 0; `dot_column` = front_buf[r].
  - SHOW→BLANK on a tick: `dot_row` = all ones; `dot_column` = 0; `r` increments and wraps ROWS-1→0.
  - The FSM does not move between ticks.
- **`frame_start`**: asserted for exactly one cycle on the edge that enters SHOW with r = 0.
- **Writes**
  - On an edge with `wr_en` = 1, `wr_data` is stored in the write buffer at `wr_row`.
  - `wr_row` ≥ ROWS: the write is ignored.
  - A write takes effect at the next SHOW of that row at the earliest.
  - The displayed row is latched at SHOW entry, so mid-slot writes do not alter the current slot.
- **All outputs are registered.**
- **Reset (asynchronous, takes effect without a clock edge)**
  - `dot_row` = all ones, `dot_column` = 0, `swap_ack` = 0, `frame_start` = 0.
  - Both buffers cleared to 0, `r` = 0, state = BLANK, prescaler = 0.
  - Reset mid-frame abandons the frame and any pending swap.

## Timing
- After reset release, the first tick falls on the DIV-th rising edge. Row 0 SHOW begins there.
- Each slot lasts exactly DIV cycles. Frame period is 2·ROWS·DIV cycles.
- With DIV = 1, the FSM toggles every cycle.
- **Swap point:** the edge where the FSM goes from SHOW with r = ROWS-1 to BLANK with r = 0.
  - `swap_req` high at that edge: the buffers exchange roles and `swap_ack` is high for the following cycle.
  - `swap_req` dropped before the swap point: the request is withdrawn and no ack is given.
  - `swap_req` still high after the ack: another swap is taken at the next frame boundary. The requester must drop `swap_req` on seeing `swap_ack`.
- **Write and swap on the same edge:** the write lands in the pre-swap back buffer, which becomes the front buffer. The data is displayed in the new frame.

## Configuration
- `DMX_DOUBLE_BUFFER_EN` defined:
  - Two ROWS×COLS buffers.
  - Writes always go to the back buffer; the display reads the front buffer.
  - Swaps occur only at the swap point, as specified under Timing.
- `DMX_DOUBLE_BUFFER_EN` undefined:
  - One buffer; writes go directly to the displayed buffer.
  - `swap_ack` is `swap_req` delayed by one cycle; no exchange occurs.
  - All other behaviour is identical.

## Test plan
All scenarios use ROWS = 8, COLS = 8, DIV = 4.
- **Reset and first row:** release reset. Required: `dot_row` = 8'hFF and `dot_column` = 8'h00 for 3 edges; on the 4th edge `dot_row` = 8'h7F, `dot_column` = 8'h00, and `frame_start` is high for 1 cycle. `frame_start` repeats every 64 cycles.
- **Pattern and blanking (single buffer):** write row 3 = 8'hC3. Required: in row 3 SHOW, `dot_row` = 8'hEF and `dot_column` = 8'hC3 for exactly 4 cycles. Each BLANK slot gives 8'hFF/8'h00 for 4 cycles.
- **Double buffer:** write all rows 8'hAA and keep `swap_req` low. Required: the display stays at 8'h00. Raise `swap_req` mid-frame. Required: `swap_ack` pulses one cycle after the row-7 SHOW→BLANK edge, and the next frame shows 8'hAA on every row.
- **Single buffer, same stimulus:** required: 8'hAA appears at the next SHOW slot, and `swap_ack` follows `swap_req` by 1 cycle.
- **Withdrawn request and collision:**
  - Drop `swap_req` before the frame boundary. Required: no ack and no swap.
  - Write row 0 = 8'h5A on the swap edge. Required: the new frame shows 8'h5A on row 0.
- **Asynchronous reset mid-frame:** assert `reset` between clock edges during row 5 SHOW. Required: `dot_row` = 8'hFF and `dot_column` = 8'h00 immediately, buffers read 0 after release, and scanning restarts at row 0 after 4 cycles.

Source files
------------

// File: rtl/dot_matrix_scan_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dot_matrix_scan_engine                                      |
// | Description : Row-scan engine for common-row LED dot-matrix panels.       |
// |               Owns a scan-rate prescaler and a writable frame buffer.     |
// |               It alternates BLANK and SHOW slots of DIV cycles each so    |
// |               that every row is preceded by a blanking slot, which        |
// |               suppresses ghosting.                                        |
// | Option      : DMX_DOUBLE_BUFFER_EN selects front/back buffers with a      |
// |               frame-synchronous swap. When it is undefined there is one   |
// |               buffer and swap_ack is swap_req delayed by one cycle.       |
// | Ports       : clk, reset (async, active-high)                             |
// |               wr_en/wr_row/wr_data  - frame-buffer row write              |
// |               swap_req/swap_ack     - buffer swap handshake               |
// |               frame_start           - pulse when row 0 SHOW begins        |
// |               dot_row (active-low one-hot), dot_column (active-high)      |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module dot_matrix_scan_engine #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DIV  = 2500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    swap_req,
  output logic                    swap_ack,
  output logic                    frame_start,
  output logic [ROWS-1:0]         dot_row,
  output logic [COLS-1:0]         dot_column
);

  localparam int c_RW = $clog2(ROWS);
  localparam int c_CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // ---------------------------------------------------------------- prescaler
  logic [c_CW-1:0] r_cnt;
  logic            w_tick;

  assign w_tick = (r_cnt == c_CW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CW'(1);
    end
  end

  // ---------------------------------------------------------------- scan state
  state_t          r_state, w_state_nxt;
  logic [c_RW-1:0] r_row, w_row_nxt;
  logic [ROWS-1:0] r_dot_row, w_dot_row_nxt;
  logic [COLS-1:0] r_dot_col, w_dot_col_nxt;
  logic            r_frame_start, w_fs_nxt;
  logic            r_swap_ack;
  logic [ROWS-1:0] w_row_sel;
  logic [COLS-1:0] w_front_data;
  logic            w_wr_ok;

  // Row r is driven on bit ROWS-1-r.
  for (genvar i = 0; i < ROWS; i++) begin : g_row_sel
    assign w_row_sel[ROWS-1-i] = (r_row == c_RW'(i));
  end

  // Rows beyond ROWS-1 are only addressable when ROWS is not a power of two.
  assign w_wr_ok = wr_en && ({1'b0, wr_row} < (c_RW + 1)'(ROWS));

  // ---------------------------------------------------------------- buffers
`ifdef DMX_DOUBLE_BUFFER_EN
  logic [COLS-1:0] r_buf [2][ROWS];
  logic            r_front;
  logic            w_swap;

  // Swap point: the SHOW(last row) -> BLANK(row 0) transition.
  assign w_swap       = w_tick && (r_state == ST_SHOW) &&
                        (r_row == c_RW'(ROWS - 1)) && swap_req;
  assign w_front_data = r_buf[r_front][r_row];

  // A write on the swap edge lands in the old back buffer, which then
  // becomes the front, so the data appears in the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < ROWS; i++) begin
          r_buf[b][i] <= '0;
        end
      end
      r_front    <= 1'b0;
      r_swap_ack <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_buf[~r_front][wr_row] <= wr_data;
      end
      if (w_swap) begin
        r_front <= ~r_front;
      end
      r_swap_ack <= w_swap;
    end
  end
`else
  logic [COLS-1:0] r_buf [ROWS];

  assign w_front_data = r_buf[r_row];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        r_buf[i] <= '0;
      end
      r_swap_ack <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_buf[wr_row] <= wr_data;
      end
      r_swap_ack <= swap_req;
    end
  end
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_BLANK;
      r_row         <= '0;
      r_dot_row     <= '1;
      r_dot_col     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_row         <= w_row_nxt;
      r_dot_row     <= w_dot_row_nxt;
      r_dot_col     <= w_dot_col_nxt;
      r_frame_start <= w_fs_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row;
    w_dot_row_nxt = r_dot_row;
    w_dot_col_nxt = r_dot_col;
    w_fs_nxt      = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_BLANK: begin
          // Column data is latched here, so later writes leave this slot alone.
          w_state_nxt   = ST_SHOW;
          w_dot_row_nxt = ~w_row_sel;
          w_dot_col_nxt = w_front_data;
          w_fs_nxt      = (r_row == '0);
        end
        default: begin
          w_state_nxt   = ST_BLANK;
          w_dot_row_nxt = '1;
          w_dot_col_nxt = '0;
          if (r_row == c_RW'(ROWS - 1)) begin
            w_row_nxt = '0;
          end else begin
            w_row_nxt = r_row + c_RW'(1);
          end
        end
      endcase
    end
  end

  assign dot_row     = r_dot_row;
  assign dot_column  = r_dot_col;
  assign frame_start = r_frame_start;
  assign swap_ack    = r_swap_ack;

endmodule
`default_nettype wire

// File: tb/tb_dot_matrix_scan_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dot_matrix_scan_engine                                   |
// | Description : Self-checking bench for dot_matrix_scan_engine with         |
// |               ROWS = 8, COLS = 8, DIV = 4. A slot-based reference model   |
// |               pushes expected outputs per edge to a scoreboard queue.     |
// |               A constant vector table and hand sequences cover the        |
// |               corner cases. DMX_DOUBLE_BUFFER_EN selects the model mode.  |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_dot_matrix_scan_engine;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DIV  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            wr_en;
  logic [2:0]      wr_row;
  logic [COLS-1:0] wr_data;
  logic            swap_req;
  logic            swap_ack;
  logic            frame_start;
  logic [ROWS-1:0] dot_row;
  logic [COLS-1:0] dot_column;

  always #5 clk = ~clk;

  dot_matrix_scan_engine #(.ROWS(ROWS), .COLS(COLS), .DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .frame_start(frame_start),
    .dot_row    (dot_row),
    .dot_column (dot_column)
  );

  typedef struct {
    logic [7:0] row;
    logic [7:0] col;
    logic       fs;
    logic       ack;
  } exp_t;

  typedef struct {
    int         t;
    logic [7:0] row;
    logic [7:0] col;
    logic       fs;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: edges since reset release, buffer contents, held outputs.
  int         m_t;
  logic [7:0] m_front [ROWS];
  logic [7:0] m_back  [ROWS];
  logic [7:0] m_row;
  logic [7:0] m_col;

  logic [7:0] obs_row [128];
  logic [7:0] obs_col [128];
  logic       obs_fs  [128];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic m_reset();
    m_t   = 0;
    m_row = 8'hFF;
    m_col = 8'h00;
    for (int i = 0; i < ROWS; i++) begin
      m_front[i] = '0;
      m_back[i]  = '0;
    end
    sb_q.delete();
  endtask

  // One clock edge: predict from the slot number, push, clock, pop and compare.
  task automatic step();
    exp_t       e;
    exp_t       want;
    int         en;
    int         s;
    int         r;
    bit         bnd;
    bit         swap_pt;
    logic [7:0] tmp;
    en      = m_t + 1;
    s       = en / DIV;
    bnd     = (en % DIV) == 0;
    swap_pt = 1'b0;
    e.fs    = 1'b0;
    if (bnd && s >= 1) begin
      if (s % 2 == 1) begin
        r                 = ((s - 1) / 2) % ROWS;
        m_row             = 8'hFF;
        m_row[ROWS-1-r]   = 1'b0;
        m_col             = m_front[r];
        e.fs              = (r == 0);
      end else begin
        m_row   = 8'hFF;
        m_col   = 8'h00;
        swap_pt = (s % (2 * ROWS)) == 0;
      end
    end
    e.row = m_row;
    e.col = m_col;
`ifdef DMX_DOUBLE_BUFFER_EN
    e.ack = swap_pt && swap_req;
    if (wr_en) m_back[wr_row] = wr_data;
    if (swap_pt && swap_req) begin
      for (int i = 0; i < ROWS; i++) begin
        tmp        = m_front[i];
        m_front[i] = m_back[i];
        m_back[i]  = tmp;
      end
    end
`else
    e.ack = swap_req;
    if (wr_en) m_front[wr_row] = wr_data;
`endif
    sb_q.push_back(e);
    m_t = en;
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    n_checks++;
    if (dot_row !== want.row || dot_column !== want.col ||
        frame_start !== want.fs || swap_ack !== want.ack) begin
      n_errors++;
      $display("FAIL scan t=%0d: got row=%h col=%h fs=%b ack=%b want row=%h col=%h fs=%b ack=%b",
               m_t, dot_row, dot_column, frame_start, swap_ack,
               want.row, want.col, want.fs, want.ack);
    end
    if (m_t < 128) begin
      obs_row[m_t] = dot_row;
      obs_col[m_t] = dot_column;
      obs_fs[m_t]  = frame_start;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   hits;
    int   k;
    int   acks;

    // Edge number after reset release -> required outputs (buffer all zero).
    vecs[0] = '{1,  8'hFF, 8'h00, 1'b0};
    vecs[1] = '{2,  8'hFF, 8'h00, 1'b0};
    vecs[2] = '{3,  8'hFF, 8'h00, 1'b0};
    vecs[3] = '{4,  8'h7F, 8'h00, 1'b1};
    vecs[4] = '{5,  8'h7F, 8'h00, 1'b0};
    vecs[5] = '{8,  8'hFF, 8'h00, 1'b0};
    vecs[6] = '{12, 8'hBF, 8'h00, 1'b0};
    vecs[7] = '{60, 8'hFE, 8'h00, 1'b0};
    vecs[8] = '{68, 8'h7F, 8'h00, 1'b1};

    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_row   = '0;
    wr_data  = '0;
    swap_req = 1'b0;
    m_reset();
    #12;
    chk("reset_row", 32'(dot_row), 32'hFF);
    chk("reset_col", 32'(dot_column), 32'h00);
    chk("reset_fs_ack", {30'd0, frame_start, swap_ack}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset and first row, frame_start period.
    repeat (70) step();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("vec_t%0d", vecs[i].t),
          {15'd0, obs_fs[vecs[i].t], obs_row[vecs[i].t], obs_col[vecs[i].t]},
          {15'd0, vecs[i].fs, vecs[i].row, vecs[i].col});
    end

    // Row 3 pattern lasts exactly one slot.
    wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'hC3;
    step();
    wr_en = 1'b0;
    hits = 0;
    repeat (64) begin
      step();
      if (dot_row == 8'hEF && dot_column == 8'hC3) hits++;
    end
`ifdef DMX_DOUBLE_BUFFER_EN
    chk("row3_slot_len", hits, 0);
`else
    chk("row3_slot_len", hits, 4);
`endif

    // Fill all rows, hold swap_req low, then request a swap.
    for (int r = 0; r < ROWS; r++) begin
      wr_en = 1'b1; wr_row = 3'(r); wr_data = 8'hAA;
      step();
    end
    wr_en = 1'b0;
    repeat (70) step();
    swap_req = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (swap_ack !== 1'b1 && k < 200);
    chk("swap_ack_seen", 32'(swap_ack), 32'd1);
    swap_req = 1'b0;
    hits = 0;
    repeat (64) begin
      step();
      if (dot_row != 8'hFF && dot_column == 8'hAA) hits++;
    end
    chk("aa_show_cycles", hits, 32);

    // Withdrawn request, well clear of the frame boundary.
    k = 0;
    while ((m_t % 64) != 20 && k < 64) begin step(); k++; end
    swap_req = 1'b1;
    acks = 0;
    repeat (5) begin step(); if (swap_ack) acks++; end
    swap_req = 1'b0;
    repeat (70) begin step(); if (swap_ack) acks++; end
`ifdef DMX_DOUBLE_BUFFER_EN
    chk("withdrawn_acks", acks, 0);
`else
    chk("withdrawn_acks", acks, 5);
`endif

    // Write row 0 on the swap edge.
    k = 0;
    while (((m_t + 1) % 64) != 0 && k < 64) begin step(); k++; end
    wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'h5A; swap_req = 1'b1;
    step();
    wr_en = 1'b0; swap_req = 1'b0;
    chk("collision_ack", 32'(swap_ack), 32'd1);
    repeat (DIV) step();
    chk("collision_row0", {16'd0, dot_row, dot_column}, {16'd0, 8'h7F, 8'h5A});

    // Asynchronous reset during row 5 SHOW.
    k = 0;
    while ((m_t % 64) != 45 && k < 64) begin step(); k++; end
    chk("pre_reset_row5", 32'(dot_row), 32'hFB);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_row", 32'(dot_row), 32'hFF);
    chk("async_reset_col", 32'(dot_column), 32'h00);
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) step();
    chk("restart_blank", {16'd0, dot_row, dot_column}, {16'd0, 8'hFF, 8'h00});
    step();
    chk("restart_row0", {15'd0, frame_start, dot_row, dot_column}, {15'd0, 1'b1, 8'h7F, 8'h00});
    hits = 0;
    repeat (64) begin step(); if (dot_column != 8'h00) hits++; end
    chk("cleared_buffers", hits, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
